keypad_scan: RTL
================

# keypad_scan

Matrix-keypad scanner for the lab board: drives the four row lines of a 4x4 push-button matrix one at a time, reads the four column lines back, debounces the whole 16-key snapshot and emits a one-cycle event carrying the 4-bit code of a newly pressed key. It is the input-side counterpart of the multiplexed 7-segment display driver, which scans outputs the same way. It sits between the keypad header pins and user logic such as a counter or register loaded by key events.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each row is held active. Must be ≥4.
- `DEBOUNCE`, default 4: number of consecutive identical frame comparisons needed to accept a new snapshot. Must be ≥1.
- `clk_i`  in  1  system clock.
- `rstn_i`  in  1  asynchronous, active-low reset.
- `col_i`  in  4  column lines, active-low (pulled up externally); asynchronous to `clk_i`.
- `row_o`  out  4  row drive, active-low one-hot; registered.
- `key_valid_o`  out  1  one-cycle pulse when a single new key is accepted.
- `key_code_o`  out  4  code of the last accepted key, `row*4 + col`; holds between events.
- `key_held_o`  out  1  high while the debounced snapshot has any key down.

## Operation
- **Input sync:** `col_i` passes through a 2-FF synchronizer and is inverted internally, so 1 = pressed.
- **Scan:**
  - A row index 0..3 and a slot counter 0..SCAN_DIV-1 run continuously from reset.
  - `row_o` drives 0 on bit `row_idx` and 1 elsewhere.
  - In the last cycle of each slot, the synchronized columns are written into `frame_snap[row_idx*4 +: 4]`.
  - The row index then advances, wrapping 3→0.
  - One frame = 4*SCAN_DIV cycles. Frame end is the sampling cycle of row 3.
- **Debounce (at frame end only):**
  - If the completed frame equals `prev_snap`: `stable_cnt` increments, saturating at DEBOUNCE.
  - When the increment reaches exactly DEBOUNCE, `deb_snap <= frame`.
  - If the frame differs from `prev_snap`: `stable_cnt <= 0`.
  - `prev_snap <= frame` on every frame end.
  - Net effect: a new pattern must be seen in DEBOUNCE+1 consecutive frames before it is accepted.
- **Event FSM** (evaluated in the cycle after `deb_snap` updates):
  - S_UP:
    - `deb_snap` has exactly one bit set → load `key_code_o` with that bit's index, pulse `key_valid_o`, go to S_DOWN.
    - More than one bit set → go to S_JAM, no pulse.
    - Zero bits → stay in S_UP.
  - S_DOWN:
    - `deb_snap` == 0 → S_UP.
    - More than one bit set → S_JAM.
    - Otherwise stay.
  - S_JAM: `deb_snap` == 0 → S_UP. No events are ever emitted from S_JAM.
- **No rollover:** a second key is never reported until every key has been released and debounced.
- `key_held_o` = (`deb_snap` != 0), registered.

## Timing
- **Reset values:**
  - Outputs: `row_o`=4'b1110, `key_valid_o`=0, `key_code_o`=0, `key_held_o`=0.
  - Internal: `row_idx`=0, slot=0, all snapshots 0, `stable_cnt`=0, state S_UP.
  - Reset applies immediately on `rstn_i` falling, independent of the clock.
- **Row timing:** after reset release, `row_o` changes exactly every SCAN_DIV cycles.
- **Settling:** column data sampled in a slot was presented at least SCAN_DIV-3 cycles after the row change, covering synchronizer delay plus line settling.
- **Event latency:**
  - `deb_snap` updates on a frame-end edge.
  - FSM output registers update on the following edge.
  - `key_valid_o` is high for exactly one cycle at frame-end+1.
  - `key_code_o` becomes valid in the same cycle as the pulse and stays stable afterwards.
- **Minimum latency:**
  - Press to event: DEBOUNCE+1 full frames after the first complete frame containing the press, plus 1 cycle.
  - Release: `key_held_o` falls with the same latency after the release.
- **Edge cases:**
  - A press spanning a frame boundary mid-frame yields an inconsistent frame. That frame only resets `stable_cnt`; there is no spurious event.
  - Reset mid-debounce discards all progress. No pulse is emitted on or after reset until a fresh full debounce completes.

## Test plan
Bench settings: SCAN_DIV=4, DEBOUNCE=2, so a frame is 16 cycles. The keypad model pulls `col_i[c]` low while key (r,c) is pressed and `row_o[r]`=0.

1. **Reset and scan:** hold reset, then release → all outputs at reset values; `row_o` steps 1110→1101→1011→0111→1110, each step lasting 4 cycles.
2. **Single press:** press key (2,1) and hold for 10 frames → exactly one `key_valid_o` pulse with `key_code_o`=9, within 4 frames; `key_held_o`=1; no further pulses.
3. **Bounce:** toggle key (1,3) every frame for 6 frames, then hold → no pulse during toggling; one pulse with code 7 after 3 stable frames.
4. **Release then re-press:** release key (2,1) → `key_held_o` falls after debounce and `key_code_o` stays 9; press key (0,0) → one pulse with code 0.
5. **Jam:** press keys 5 and 10 together → no pulse, `key_held_o`=1; release key 10 only → still no pulse; release all, then press key 5 → one pulse with code 5.
6. **Reset mid-debounce:** pulse `rstn_i` low 1 frame after a press starts → outputs reset asynchronously; the key stays held, and exactly one pulse follows after a full debounce from row 0.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: row strobing, column sync, frame debounce,
// single-key event generation with no rollover.
module keypad_scan #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [3:0] col_i,
  output logic [3:0] row_o,
  output logic       key_valid_o,
  output logic [3:0] key_code_o,
  output logic       key_held_o
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_MAX   = CW'(DEBOUNCE);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    S_UP   = 2'd0,
    S_DOWN = 2'd1,
    S_JAM  = 2'd2
  } state_t;

  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [SW-1:0] r_slot;
  logic [1:0]    r_row_idx;
  logic [3:0]    r_row;
  logic [15:0]   r_frame;
  logic [15:0]   r_prev;
  logic [15:0]   r_deb;
  logic [CW-1:0] r_cnt;
  state_t        r_state;
  logic          r_valid;
  logic [3:0]    r_code;
  logic          r_held;

  logic [3:0]    w_col;
  logic          w_slot_end;
  logic          w_frame_end;
  logic [1:0]    w_row_nxt;
  logic [15:0]   w_frame;
  logic [4:0]    w_ones;
  logic [3:0]    w_idx;
  logic          w_none;
  logic          w_single;
  logic          w_multi;
  state_t        w_state_nxt;
  logic          w_valid_nxt;
  logic [3:0]    w_code_nxt;

  assign w_col       = ~r_sync2;
  assign w_slot_end  = (r_slot == SLOT_LAST);
  assign w_frame_end = w_slot_end && (r_row_idx == 2'd3);
  assign w_row_nxt   = r_row_idx + 2'd1;

  // Frame as it stands including the row being sampled this cycle
  always_comb begin
    w_frame = r_frame;
    w_frame[{r_row_idx, 2'b00} +: 4] = w_col;
  end

  // Sync FFs idle high so reset does not look like all keys pressed
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= col_i;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_slot    <= '0;
      r_row_idx <= 2'd0;
      r_row     <= 4'b1110;
      r_frame   <= '0;
    end else if (w_slot_end) begin
      r_slot    <= '0;
      r_row_idx <= w_row_nxt;
      r_row     <= ~(4'b0001 << w_row_nxt);
      r_frame   <= w_frame;
    end else begin
      r_slot    <= r_slot + SW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_prev <= '0;
      r_deb  <= '0;
      r_cnt  <= '0;
    end else if (w_frame_end) begin
      r_prev <= w_frame;
      if (w_frame == r_prev) begin
        if (r_cnt != DEB_MAX) begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == DEB_LAST) begin
            r_deb <= w_frame;
          end
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_ones = 5'd0;
    w_idx  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (r_deb[i]) begin
        w_ones = w_ones + 5'd1;
        w_idx  = 4'(i);
      end
    end
  end

  assign w_none   = (w_ones == 5'd0);
  assign w_single = (w_ones == 5'd1);
  assign w_multi  = (w_ones > 5'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = 1'b0;
    w_code_nxt  = r_code;
    unique case (r_state)
      S_UP: begin
        unique case (1'b1)
          w_multi: w_state_nxt = S_JAM;
          w_single: begin
            w_state_nxt = S_DOWN;
            w_valid_nxt = 1'b1;
            w_code_nxt  = w_idx;
          end
          default: w_state_nxt = S_UP;
        endcase
      end
      S_DOWN: begin
        unique case (1'b1)
          w_none:  w_state_nxt = S_UP;
          w_multi: w_state_nxt = S_JAM;
          default: w_state_nxt = S_DOWN;
        endcase
      end
      S_JAM: begin
        if (w_none) begin
          w_state_nxt = S_UP;
        end
      end
      default: w_state_nxt = S_UP;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_UP;
      r_valid <= 1'b0;
      r_code  <= 4'd0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_code  <= w_code_nxt;
      r_held  <= |r_deb;
    end
  end

  assign row_o       = r_row;
  assign key_valid_o = r_valid;
  assign key_code_o  = r_code;
  assign key_held_o  = r_held;

endmodule
